// File: rtl/aqu_bridge_n.sv
// aqu_bridge_n
// AHB-Lite slave that bridges CPU transfers onto one of NCH Aquarius
// peripheral channels. The channel is decoded from HADDR[CH_LSB +: CHW].
// The bridge strobes that channel and waits for its ACK. It returns the read
// data, or an AHB two-cycle ERROR response on timeout, misalignment or an
// unmapped channel.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   HSEL..HREADY      AHB-Lite slave inputs (address phase + HWDATA)
//   HREADYOUT, HRESP  AHB-Lite slave response
//   HRDATA            last captured read data (held until next read)
//   CE                one-hot channel enable, active only while BUSY
//   STB, WE, SEL, ADR peripheral strobe / write / big-endian lanes / address
//   DATA              write data, HWDATA passed through while BUSY
//   ACK               per-channel acknowledge
//   RDATA             per-channel read data, channel k at RDATA[32k +: 32]
module aqu_bridge_n #(
  parameter int NCH     = 4,
  parameter int CH_LSB  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [NCH-1:0]    CE,
  output logic              STB,
  output logic              WE,
  output logic [3:0]        SEL,
  output logic [31:0]       ADR,
  output logic [31:0]       DATA,
  input  logic [NCH-1:0]    ACK,
  input  logic [NCH*32-1:0] RDATA
);

  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       adr_reg;
  logic              we_reg;
  logic [3:0]        sel_reg;
  logic [CHW-1:0]    ch_reg;
  logic [CNTW-1:0]   cnt_reg;
  logic [31:0]       hrdata_reg;

  // Address-phase decode
  logic [CHW-1:0]    req_ch;
  logic              req_ch_ok;
  logic              req_aligned;
  logic [3:0]        req_sel;
  logic              slave_ready;
  logic              accept;
  logic              req_valid;

  // Selected-channel view of the peripheral side
  logic [NCH-1:0]    ch_dec;
  logic              ack_sel;
  logic [31:0]       rdata_sel;
  logic              busy;
  logic              timeout_hit;
  logic              cnt_sat;

  // HTRANS[0] only distinguishes SEQ from NONSEQ, which are handled alike.
  logic              unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  assign req_ch    = HADDR[CH_LSB +: CHW];
  assign req_ch_ok = (32'(req_ch) < NCH);

  // Big-endian lanes: byte address 0 is SEL[3]. The transfer size is fully
  // captured by the latched lane mask, so HSIZE itself is not kept.
  always_comb begin
    req_sel     = 4'b0000;
    req_aligned = 1'b0;
    case (HSIZE)
      3'd0: begin
        req_sel     = 4'b1000 >> HADDR[1:0];
        req_aligned = 1'b1;
      end
      3'd1: begin
        req_sel     = HADDR[1] ? 4'b0011 : 4'b1100;
        req_aligned = ~HADDR[0];
      end
      3'd2: begin
        req_sel     = 4'b1111;
        req_aligned = (HADDR[1:0] == 2'b00);
      end
      default: begin
        req_sel     = 4'b0000;
        req_aligned = 1'b0;
      end
    endcase
  end

  assign slave_ready = (state_reg == S_IDLE) || (state_reg == S_DONE) ||
                       (state_reg == S_ERR2);
  assign accept      = slave_ready && HSEL && HREADY && HTRANS[1];
  assign req_valid   = req_aligned && req_ch_ok;

  // One-hot decode of the latched channel; ACK and RDATA from any other
  // channel are masked off here, which is what makes stray ACKs harmless.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch_dec
      assign ch_dec[gi] = (ch_reg == CHW'(gi));
    end
  endgenerate

  always_comb begin
    rdata_sel = 32'h0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_dec[k]) begin
        rdata_sel = rdata_sel | RDATA[32*k +: 32];
      end
    end
  end

  assign busy    = (state_reg == S_BUSY);
  assign ack_sel = |(ACK & ch_dec);
  assign cnt_sat = (cnt_reg == {CNTW{1'b1}});

  // Counter holds the number of completed ACK-less BUSY cycles. The move to
  // ERR1 is taken at the end of the TIMEOUT-th such cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNTW'(TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          state_next = req_valid ? S_BUSY : S_ERR1;
        end else if (HREADY) begin
          state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        // ACK takes priority over a timeout in the same cycle
        if (ack_sel) begin
          state_next = S_DONE;
        end else if (timeout_hit) begin
          state_next = S_ERR1;
        end
      end
      S_ERR1:  state_next = S_ERR2;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      adr_reg    <= 32'h0;
      we_reg     <= 1'b0;
      sel_reg    <= 4'b0000;
      ch_reg     <= '0;
      cnt_reg    <= '0;
      hrdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (accept && req_valid) begin
        adr_reg <= HADDR;
        we_reg  <= HWRITE;
        sel_reg <= req_sel;
        ch_reg  <= req_ch;
        cnt_reg <= '0;
      end else if (busy && !ack_sel && !cnt_sat) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (busy && ack_sel && !we_reg) begin
        hrdata_reg <= rdata_sel;
      end
    end
  end

  // Peripheral-side outputs are only driven while BUSY, so they stay at
  // their inactive values in every other state.
  assign HREADYOUT = slave_ready;
  assign HRESP     = (state_reg == S_ERR1) || (state_reg == S_ERR2);
  assign HRDATA    = hrdata_reg;
  assign STB       = busy;
  assign CE        = busy ? ch_dec : '0;
  assign WE        = busy && we_reg;
  assign SEL       = busy ? sel_reg : 4'b0000;
  assign ADR       = busy ? adr_reg : 32'h0;
  assign DATA      = busy ? HWDATA : 32'h0;

endmodule

// File: tb/tb_aqu_bridge_n.sv
// Directed bench for aqu_bridge_n (NCH=5, CH_LSB=16, TIMEOUT=4).
// Inputs change 1 time unit after the rising edge and outputs are sampled on
// the falling edge. HREADY is looped back from HREADYOUT, as with a single slave.
module tb_aqu_bridge_n;

  localparam int NCH = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [NCH-1:0]    CE;
  logic              STB;
  logic              WE;
  logic [3:0]        SEL;
  logic [31:0]       ADR;
  logic [31:0]       DATA;
  logic [NCH-1:0]    ACK;
  logic [NCH*32-1:0] RDATA;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign HREADY = HREADYOUT;

  aqu_bridge_n #(.NCH(NCH), .CH_LSB(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .CE(CE),
    .STB(STB), .WE(WE), .SEL(SEL), .ADR(ADR), .DATA(DATA), .ACK(ACK),
    .RDATA(RDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr(input logic [31:0] a, input logic [2:0] sz, input logic wr);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HSIZE  = sz;
    HWRITE = wr;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  initial begin
    rst = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HSIZE = 3'd0;
    HWRITE = 1'b0; HWDATA = 32'h1234_5678; ACK = '0; RDATA = '0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_hreadyout", HREADYOUT, 1); chk("rst_hresp", HRESP, 0);
    chk("rst_hrdata", HRDATA, 0); chk("rst_ce", CE, 0); chk("rst_stb", STB, 0);
    chk("rst_we", WE, 0); chk("rst_sel", SEL, 0); chk("rst_adr", ADR, 0);
    chk("rst_data_gated", DATA, 0);
    tick(); rst = 1'b0;
    $display("reset: checks=%0d errors=%0d", checks, errors);

    // Word read, ch2, ACK in first BUSY cycle
    tick(); addr(32'h0002_0004, 3'd2, 1'b0);
    @(negedge clk); chk("rd_a_ready", HREADYOUT, 1);
    tick(); bus_idle(); ACK = 5'b00100; RDATA[64 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_stb", STB, 1); chk("rd_ce", CE, 5'b00100); chk("rd_sel", SEL, 4'b1111);
    chk("rd_adr", ADR, 32'h0002_0004); chk("rd_we", WE, 0); chk("rd_busy_ready", HREADYOUT, 0);
    tick(); ACK = '0;
    @(negedge clk);
    chk("rd_done_stb", STB, 0); chk("rd_done_ce", CE, 0); chk("rd_done_ready", HREADYOUT, 1);
    chk("rd_done_hresp", HRESP, 0); chk("rd_hrdata", HRDATA, 32'hDEAD_BEEF);
    $display("word read ch2: checks=%0d errors=%0d", checks, errors);

    // Byte write ch1, ACK[1] in the third BUSY cycle
    tick(); addr(32'h0001_0003, 3'd0, 1'b1); RDATA[32 +: 32] = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin bus_idle(); HWDATA = 32'h0000_00A5; end
      if (i == 2) ACK = 5'b00010;
      @(negedge clk);
      chk("wr_stb", STB, 1); chk("wr_we", WE, 1); chk("wr_sel", SEL, 4'b0001);
      chk("wr_data", DATA, 32'h0000_00A5); chk("wr_ce", CE, 5'b00010);
      chk("wr_ready_low", HREADYOUT, 0);
    end
    tick(); ACK = '0;
    @(negedge clk);
    chk("wr_done_ready", HREADYOUT, 1); chk("wr_done_hresp", HRESP, 0);
    chk("wr_hrdata_kept", HRDATA, 32'hDEAD_BEEF); chk("wr_done_stb", STB, 0);
    chk("wr_done_data_gated", DATA, 0);
    $display("byte write ch1: checks=%0d errors=%0d", checks, errors);

    // Timeout on ch0: 4 BUSY cycles, ERR1, ERR2, IDLE
    tick(); addr(32'h0000_0000, 3'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) bus_idle();
      @(negedge clk);
      chk("to_busy_stb", STB, 1); chk("to_busy_ready", HREADYOUT, 0);
    end
    tick(); @(negedge clk);
    chk("to_err1_ready", HREADYOUT, 0); chk("to_err1_hresp", HRESP, 1); chk("to_err1_stb", STB, 0);
    tick(); @(negedge clk);
    chk("to_err2_ready", HREADYOUT, 1); chk("to_err2_hresp", HRESP, 1); chk("to_err2_stb", STB, 0);
    tick(); @(negedge clk);
    chk("to_idle_hresp", HRESP, 0); chk("to_idle_ready", HREADYOUT, 1);
    $display("timeout: checks=%0d errors=%0d", checks, errors);

    // ACK on ch4 in the same cycle the timeout would fire: ACK wins
    tick(); addr(32'h0004_0010, 3'd2, 1'b0); RDATA[128 +: 32] = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) bus_idle();
      if (i == 3) ACK = 5'b10000;
      @(negedge clk);
      chk("tob_stb", STB, 1); chk("tob_ce", CE, 5'b10000);
    end
    tick(); ACK = '0;
    @(negedge clk);
    chk("tob_done_ready", HREADYOUT, 1); chk("tob_done_hresp", HRESP, 0);
    chk("tob_hrdata", HRDATA, 32'h0BAD_F00D);
    $display("ack at timeout: checks=%0d errors=%0d", checks, errors);

    // Misaligned half-word
    tick(); addr(32'h0000_0001, 3'd1, 1'b0);
    tick(); bus_idle(); @(negedge clk);
    chk("mis_err1_ready", HREADYOUT, 0); chk("mis_err1_hresp", HRESP, 1); chk("mis_err1_stb", STB, 0);
    tick(); @(negedge clk);
    chk("mis_err2_ready", HREADYOUT, 1); chk("mis_err2_hresp", HRESP, 1); chk("mis_err2_stb", STB, 0);
    $display("misaligned half: checks=%0d errors=%0d", checks, errors);

    // Unmapped channel 5 (NCH=5)
    tick(); addr(32'h0005_0000, 3'd2, 1'b0);
    tick(); bus_idle(); @(negedge clk);
    chk("ch5_err1_ready", HREADYOUT, 0); chk("ch5_err1_hresp", HRESP, 1);
    chk("ch5_err1_stb", STB, 0); chk("ch5_err1_ce", CE, 0);
    tick(); @(negedge clk);
    chk("ch5_err2_ready", HREADYOUT, 1); chk("ch5_err2_hresp", HRESP, 1); chk("ch5_err2_stb", STB, 0);
    $display("unmapped ch5: checks=%0d errors=%0d", checks, errors);

    // Back-to-back reads ch0 then ch3, stray ACK[1] during ch3
    tick(); addr(32'h0000_0008, 3'd2, 1'b0); RDATA[0 +: 32] = 32'h1111_1111;
    tick(); addr(32'h0003_0000, 3'd2, 1'b0); ACK = 5'b00001;
    @(negedge clk);
    chk("b2b0_stb", STB, 1); chk("b2b0_ce", CE, 5'b00001); chk("b2b0_ready", HREADYOUT, 0);
    tick(); ACK = '0;
    @(negedge clk);
    chk("b2b0_done_stb", STB, 0); chk("b2b0_done_ready", HREADYOUT, 1);
    chk("b2b0_hrdata", HRDATA, 32'h1111_1111);
    tick(); bus_idle(); ACK = 5'b00010; RDATA[96 +: 32] = 32'h3333_3333;
    @(negedge clk);
    chk("b2b3_stb", STB, 1); chk("b2b3_ce", CE, 5'b01000); chk("b2b3_adr", ADR, 32'h0003_0000);
    tick(); ACK = '0;
    @(negedge clk);
    chk("b2b3_stray_ignored", HREADYOUT, 0); chk("b2b3_still_stb", STB, 1);
    tick(); ACK = 5'b01000;
    @(negedge clk); chk("b2b3_ack_stb", STB, 1);
    tick(); ACK = '0;
    @(negedge clk);
    chk("b2b3_done_ready", HREADYOUT, 1); chk("b2b3_hrdata", HRDATA, 32'h3333_3333);
    $display("back-to-back: checks=%0d errors=%0d", checks, errors);

    // Reset during BUSY, ACK arrives the following cycle
    tick(); addr(32'h0002_0000, 3'd2, 1'b0); RDATA[64 +: 32] = 32'hCAFE_F00D;
    tick(); bus_idle(); rst = 1'b1;
    @(negedge clk); chk("mrst_busy_stb", STB, 1);
    tick(); rst = 1'b0; ACK = 5'b00100;
    @(negedge clk);
    chk("mrst_stb", STB, 0); chk("mrst_ce", CE, 0); chk("mrst_ready", HREADYOUT, 1);
    chk("mrst_hresp", HRESP, 0); chk("mrst_hrdata", HRDATA, 0); chk("mrst_sel", SEL, 0);
    chk("mrst_adr", ADR, 0); chk("mrst_we", WE, 0);
    tick(); ACK = '0;
    @(negedge clk);
    chk("mrst_late_ack_hrdata", HRDATA, 0); chk("mrst_late_ack_stb", STB, 0);
    $display("reset mid-transfer: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
